// File: rtl/pc_branch_ctrl.sv
// ============================================================================
// Module   : pc_branch_ctrl
// Brief    : Program counter, flag register and branch resolution with an
//            IDLE/RUN/DONE run sequencer. Optional macro PCCTL_TRACE_EN adds
//            the InstrCount trace counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_branch_ctrl #(
    parameter int PW = 10
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          Start,
    input  logic [PW-1:0] StartAddr,
    input  logic          Stall,
    input  logic          HaltReq,
    input  logic          JumpEn,
    input  logic          BranchEn,
    input  logic [1:0]    BranchCond,
    input  logic          RelEn,
    input  logic [PW-1:0] Target,
    input  logic          FlagLoad,
    input  logic          Zero,
    input  logic          Parity,
    input  logic          Odd,
`ifdef PCCTL_TRACE_EN
    output logic [15:0]   InstrCount,
`endif
    output logic [PW-1:0] PC,
    output logic          Running,
    output logic          Done,
    output logic          BranchTaken,
    output logic          FlagZ,
    output logic          FlagP,
    output logic          FlagO
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] C_ZERO   = 2'b00;
    localparam logic [1:0] C_NZERO  = 2'b01;
    localparam logic [1:0] C_PARITY = 2'b10;

    localparam logic [PW-1:0] PC_ONE = {{(PW-1){1'b0}}, 1'b1};

    logic [1:0]    state;
    logic [1:0]    next_state;

    logic [PW-1:0] pc;
    logic [PW-1:0] pc_next;
    logic          taken;
    logic          taken_next;
    logic          flag_z;
    logic          flag_p;
    logic          flag_o;
    logic          flag_load_en;
    logic          cond_true;
    logic [PW-1:0] branch_tgt;
    logic          start_run;
    logic          run_active;

    assign run_active = (state == S_RUN);
    assign start_run  = (state != S_RUN) && Start;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (Start)   next_state = S_RUN;
            S_RUN:  if (HaltReq) next_state = S_DONE;
            S_DONE: if (Start)   next_state = S_RUN;
            default:             next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        Running = 1'b0;
        Done    = 1'b0;
        case (state)
            S_RUN:   Running = 1'b1;
            S_DONE:  Done    = 1'b1;
            default: ;
        endcase
    end

    // Conditions look only at the registered flags, so a branch right after
    // a compare sees that compare's result.
    always_comb begin
        cond_true = 1'b0;
        case (BranchCond)
            C_ZERO:   cond_true = flag_z;
            C_NZERO:  cond_true = !flag_z;
            C_PARITY: cond_true = flag_p;
            default:  cond_true = flag_o;
        endcase
    end

    assign branch_tgt = RelEn ? (pc + Target) : Target;

    always_comb begin
        pc_next    = pc;
        taken_next = taken;
        if (start_run) begin
            pc_next    = StartAddr;
            taken_next = 1'b0;
        end else if (run_active) begin
            if (HaltReq) begin
                taken_next = 1'b0;
            end else if (Stall) begin
                taken_next = taken;
            end else if (JumpEn || (BranchEn && cond_true)) begin
                pc_next    = branch_tgt;
                taken_next = 1'b1;
            end else begin
                pc_next    = pc + PC_ONE;
                taken_next = 1'b0;
            end
        end
    end

    assign flag_load_en = run_active && !Stall && !HaltReq && FlagLoad;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pc     <= '0;
            taken  <= 1'b0;
            flag_z <= 1'b0;
            flag_p <= 1'b0;
            flag_o <= 1'b0;
        end else begin
            pc    <= pc_next;
            taken <= taken_next;
            if (flag_load_en) begin
                flag_z <= Zero;
                flag_p <= Parity;
                flag_o <= Odd;
            end
        end
    end

    assign PC          = pc;
    assign BranchTaken = taken;
    assign FlagZ       = flag_z;
    assign FlagP       = flag_p;
    assign FlagO       = flag_o;

`ifdef PCCTL_TRACE_EN
    logic [15:0] instr_count;

    // Counts every unstalled RUN cycle, the halt cycle included.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            instr_count <= '0;
        end else if (start_run) begin
            instr_count <= '0;
        end else if (run_active && !Stall && (instr_count != 16'hFFFF)) begin
            instr_count <= instr_count + 16'd1;
        end
    end

    assign InstrCount = instr_count;
`endif

endmodule

`default_nettype wire
